// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths and FSM encoding for the ALU issue/retire stage.
package alu_issue_ctrl_pkg;
  localparam int W   = 13;
  localparam int OPW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module alu_cmd_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW    = 2 * alu_issue_ctrl_pkg::W + alu_issue_ctrl_pkg::OPW,
  parameter int DEPTH = 4
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered commands to the ALU one at a time and returns tagged responses.
//   state | meaning
//   IDLE  | no command in flight, waiting for FIFO data
//   WAIT  | operands on ALU, latency counter running
//   RESP  | response held until consumer accepts
module alu_issue_ctrl #(
  parameter int W       = alu_issue_ctrl_pkg::W,
  parameter int OPW     = alu_issue_ctrl_pkg::OPW,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [W-1:0]   cmd_x,
  input  logic [W-1:0]   cmd_y,
  input  logic [OPW-1:0] cmd_op,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic [OPW-1:0] alu_opcode,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_status,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_status,
  output logic [OPW-1:0] rsp_op,
  output logic           busy
);
  import alu_issue_ctrl_pkg::*;

  localparam int CW = $clog2(ALU_LAT + 1);
  localparam int DW = 2 * W + OPW;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] head;

  alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    ({cmd_x, cmd_y, cmd_op}),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // No pass-through: a full FIFO refuses even when a pop is happening.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign cnt_tc    = (cnt == CW'(1));
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt_tc) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_status <= 1'b0;
      rsp_op     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        {alu_x, alu_y, alu_opcode} <= head;
        cnt <= CW'(ALU_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (state == WAIT && cnt_tc) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_status <= alu_status;
        rsp_op     <= alu_opcode;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at ALU_LAT=1, one at ALU_LAT=3.
module tb_alu_issue_ctrl;
  localparam int W   = 13;
  localparam int OPW = 3;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [OPW-1:0] op;
    logic [W-1:0]   res;
    logic           st;
  } vec_t;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   cmd_x = '0;
  logic [W-1:0]   cmd_y = '0;
  logic [OPW-1:0] cmd_op = '0;

  logic           cmd_ready, rsp_valid, rsp_status, busy, alu_status;
  logic [W-1:0]   alu_x, alu_y, alu_result, rsp_result;
  logic [OPW-1:0] alu_opcode, rsp_op;

  logic           cmd_ready_3, rsp_valid_3, rsp_status_3, busy_3, alu_status_3;
  logic [W-1:0]   alu_x_3, alu_y_3, alu_result_3, rsp_result_3;
  logic [OPW-1:0] alu_opcode_3, rsp_op_3;

  int   total = 0;
  int   bad = 0;
  vec_t cur [8];
  int   rsp_cyc [8];

  always #5 aclk = ~aclk;

  // Simple combinational ALU stand-in; status flags a zero result.
  function automatic logic [W:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [OPW-1:0] op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x & y;
      3'd3:    r = x | y;
      3'd4:    r = x ^ y;
      3'd5:    r = x << 1;
      3'd6:    r = x >> 1;
      default: r = y;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_status, alu_result}     = alu_f(alu_x, alu_y, alu_opcode);
  assign {alu_status_3, alu_result_3} = alu_f(alu_x_3, alu_y_3, alu_opcode_3);

  alu_issue_ctrl #(.W(W), .OPW(OPW), .DEPTH(4), .ALU_LAT(1)) dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .rsp_op(rsp_op), .busy(busy)
  );

  alu_issue_ctrl #(.W(W), .OPW(OPW), .DEPTH(4), .ALU_LAT(3)) dut3 (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_3),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op),
    .alu_x(alu_x_3), .alu_y(alu_y_3), .alu_opcode(alu_opcode_3),
    .alu_result(alu_result_3), .alu_status(alu_status_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_result(rsp_result_3),
    .rsp_status(rsp_status_3), .rsp_op(rsp_op_3), .busy(busy_3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    areset    = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic push_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic [OPW-1:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_x = x;
    cmd_y = y;
    cmd_op = op;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Push cur[0..n-1] while collecting responses; rsp_ready stays low for the first hold cycles.
  task automatic stream(input int n, input int hold, output int got);
    int pi = 0;
    int ri = 0;
    int cyc = 0;
    bit pf;
    while ((pi < n || ri < n) && cyc < 200) begin
      rsp_ready = (cyc >= hold);
      cmd_valid = (pi < n);
      if (pi < n) begin
        cmd_x = cur[pi].x;
        cmd_y = cur[pi].y;
        cmd_op = cur[pi].op;
      end
      pf = cmd_valid && cmd_ready;
      if (rsp_valid && rsp_ready) begin
        if (ri < n) begin
          chk("rsp_op", rsp_op, cur[ri].op);
          chk("rsp_result", rsp_result, cur[ri].res);
          chk("rsp_status", rsp_status, cur[ri].st);
          rsp_cyc[ri] = cyc;
        end
        ri++;
      end
      if (hold > 0 && cyc == hold - 1) begin
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_accepted", pi, 5);
      end
      tick();
      if (pf) pi++;
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (cyc >= 200) chk("stream_timeout", cyc, 0);
    got = ri;
  endtask

  initial begin
    int got;
    int n;
    bit stale;

    // Reset state
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_x, alu_y, alu_opcode}, 0);
    chk("rst_rsp", {rsp_result, rsp_status, rsp_op}, 0);
    areset = 1'b0;
    tick();

    // Single op, checked edge by edge on both latencies
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_x = 13'd4; cmd_y = 13'd2; cmd_op = 3'd0;
    tick();
    cmd_valid = 1'b0;
    chk("single_alu_before", alu_x, 0);
    tick();
    chk("single_alu_x", alu_x, 4);
    chk("single_alu_y", alu_y, 2);
    chk("single_valid_early", rsp_valid, 0);
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_op", rsp_op, 0);
    chk("single_result", rsp_result, 6);
    chk("lat3_valid_e3", rsp_valid_3, 0);
    tick();
    chk("single_retired", rsp_valid, 0);
    chk("lat3_valid_e4", rsp_valid_3, 0);
    tick();
    chk("lat3_valid_e5", rsp_valid_3, 1);
    chk("lat3_result", rsp_result_3, 6);
    tick();
    chk("single_idle_busy", busy, 0);
    chk("lat3_idle_busy", busy_3, 0);

    // Opcode sweep, hand-computed for x=4, y=2
    do_reset();
    cur[0] = '{13'd4, 13'd2, 3'd0, 13'd6, 1'b0};
    cur[1] = '{13'd4, 13'd2, 3'd1, 13'd2, 1'b0};
    cur[2] = '{13'd4, 13'd2, 3'd2, 13'd0, 1'b1};
    cur[3] = '{13'd4, 13'd2, 3'd3, 13'd6, 1'b0};
    cur[4] = '{13'd4, 13'd2, 3'd4, 13'd6, 1'b0};
    cur[5] = '{13'd4, 13'd2, 3'd5, 13'd8, 1'b0};
    cur[6] = '{13'd4, 13'd2, 3'd6, 13'd2, 1'b0};
    cur[7] = '{13'd4, 13'd2, 3'd7, 13'd2, 1'b0};
    stream(8, 0, got);
    chk("sweep_count", got, 8);
    for (int k = 1; k < 8; k++) chk("sweep_spacing", rsp_cyc[k] - rsp_cyc[k-1], 2);
    tick(); tick();
    chk("sweep_no_extra", rsp_valid, 0);

    // Full: responses blocked, 5 accepted, then everything drains in order
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cur[k].x  = W'(k + 3);
      cur[k].y  = 13'd1;
      cur[k].op = OPW'(k);
      {cur[k].st, cur[k].res} = alu_f(cur[k].x, cur[k].y, cur[k].op);
    end
    stream(6, 10, got);
    chk("full_count", got, 6);
    tick(); tick();
    chk("full_drained", busy, 0);

    // Backpressure in RESP
    do_reset();
    rsp_ready = 1'b0;
    push_one(13'd100, 13'd7, 3'd1);
    push_one(13'd5, 13'd9, 3'd4);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_hold", {rsp_valid, rsp_result, rsp_op, rsp_status}, {1'b1, 13'd93, 3'd1, 1'b0});
      chk("bp_alu_hold", {alu_x, alu_y, alu_opcode}, {13'd100, 13'd7, 3'd1});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_issue", {alu_x, alu_y, alu_opcode}, {13'd5, 13'd9, 3'd4});
    chk("bp_valid_clear", rsp_valid, 0);
    tick();
    chk("bp_second_rsp", {rsp_valid, rsp_result, rsp_op}, {1'b1, 13'd12, 3'd4});
    tick();
    chk("bp_done", {rsp_valid, busy}, 0);

    // Reset while WAIT with two commands queued
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_one(W'(10 + k), 13'd1, OPW'(0));
    rsp_ready = 1'b1;
    tick();
    chk("rstw_issued", alu_x, 11);
    chk("rstw_busy_pre", busy, 1);
    #2 areset = 1'b1;
    #1;
    chk("rstw_valid", rsp_valid, 0);
    chk("rstw_busy", {busy, busy_3}, 0);
    chk("rstw_cmd_ready", cmd_ready, 1);
    chk("rstw_outputs", {alu_x, rsp_result}, 0);
    @(posedge aclk);
    #1 areset = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) stale = 1'b1;
      tick();
    end
    chk("rstw_no_stale", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
